// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs one wide (4*NIBBLES-bit) ALU command through an external
// 4-bit registered ALU, one nibble per two cycles, least significant nibble first.
// The carry is chained between nibbles. The result returns on a valid/ready response.
// Optional feature: define ALU_NIBBLE_SEQ_FLAGS_EN to produce {N, Z, V} in o_rsp_flags.
// Without it, o_rsp_flags is tied to zero.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [2:0]             i_cmd_op,
    input  logic [4*NIBBLES-1:0]   i_cmd_a,
    input  logic [4*NIBBLES-1:0]   i_cmd_b,
    input  logic                   i_cmd_cin,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [4*NIBBLES-1:0]   o_rsp_result,
    output logic                   o_rsp_carry,
    output logic                   o_rsp_err,
    output logic [2:0]             o_rsp_flags,
    output logic [3:0]             o_alu_in1,
    output logic [3:0]             o_alu_in2,
    output logic                   o_alu_c_in,
    output logic [24:0]            o_alu_op,
    input  logic [3:0]             i_alu_out,
    input  logic                   i_alu_c_out
);
    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;

    // ALU op strings are right-aligned ASCII; zero selects no ALU operation.
    localparam logic [24:0] ALU_PLUS  = 25'h00002B;
    localparam logic [24:0] ALU_AND   = 25'h000026;
    localparam logic [24:0] ALU_OR    = 25'h00007C;
    localparam logic [24:0] ALU_XOR   = 25'h00005E;
    localparam logic [24:0] ALU_TILDE = 25'h00007E;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t         r_state, w_state_next;
    logic [W-1:0]   r_a, r_b, r_acc, w_a_next, w_b_next, w_acc_next, w_acc_upd;
    logic [2:0]     r_op, w_op_next, r_idx, w_idx_next, w_idx_inc;
    logic           r_cmd_ready, w_cmd_ready_next;
    logic           r_rsp_valid, w_rsp_valid_next;
    logic [W-1:0]   r_rsp_result, w_rsp_result_next;
    logic           r_rsp_carry, w_rsp_carry_next;
    logic           r_rsp_err, w_rsp_err_next;
    logic [3:0]     r_alu_in1, r_alu_in2, w_alu_in1_next, w_alu_in2_next;
    logic           r_alu_c_in, w_alu_c_in_next;
    logic [24:0]    r_alu_op, w_alu_op_next;

    logic [2:0]     w_src_op;
    logic [3:0]     w_src_a, w_src_b;
    logic           w_src_carry;
    logic [3:0]     w_drv_in1, w_drv_in2;
    logic           w_drv_c_in;
    logic [24:0]    w_drv_op;
    logic           w_is_arith;

    assign w_idx_inc  = r_idx + 3'd1;
    assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Select the nibble to issue next: nibble 0 straight from the command on accept, otherwise the following latched nibble.
    always_comb begin
        w_src_op    = r_op;
        w_src_a     = 4'h0;
        w_src_b     = 4'h0;
        w_src_carry = i_alu_c_out;
        if (r_state == IDLE) begin
            w_src_op    = i_cmd_op;
            w_src_a     = i_cmd_a[3:0];
            w_src_b     = i_cmd_b[3:0];
            w_src_carry = (i_cmd_op == OP_SUB) ? 1'b1 : i_cmd_cin;
        end else begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (3'(n) == w_idx_inc) begin
                    w_src_a = r_a[4*n +: 4];
                    w_src_b = r_b[4*n +: 4];
                end
            end
        end
    end

    // Translate a wide op into the 4-bit ALU operation; subtraction is add of the inverted operand with carry-in.
    always_comb begin
        w_drv_in1  = w_src_a;
        w_drv_in2  = w_src_b;
        w_drv_c_in = 1'b0;
        w_drv_op   = 25'h0;
        case (w_src_op)
            OP_ADD: begin
                w_drv_op   = ALU_PLUS;
                w_drv_c_in = w_src_carry;
            end
            OP_SUB: begin
                w_drv_in2  = ~w_src_b;
                w_drv_op   = ALU_PLUS;
                w_drv_c_in = w_src_carry;
            end
            OP_AND: w_drv_op = ALU_AND;
            OP_OR:  w_drv_op = ALU_OR;
            OP_XOR: w_drv_op = ALU_XOR;
            OP_NOT: begin
                w_drv_in2 = 4'h0;
                w_drv_op  = ALU_TILDE;
            end
            default: begin
                w_drv_in1 = 4'h0;
                w_drv_in2 = 4'h0;
            end
        endcase
    end

    // Merge the ALU result into the accumulator slot of the nibble that is currently being captured.
    always_comb begin
        w_acc_upd = r_acc;
        for (int n = 0; n < NIBBLES; n++) begin
            if (3'(n) == r_idx) begin
                w_acc_upd[4*n +: 4] = i_alu_out;
            end
        end
    end

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
    logic [2:0] r_rsp_flags, w_rsp_flags_next, w_flags_final;
    logic       w_b_eff_msb, w_overflow;

    // Derive {N, Z, V} from the completed result and the effective operand signs.
    always_comb begin
        w_b_eff_msb   = (r_op == OP_SUB) ? ~r_b[W-1] : r_b[W-1];
        w_overflow    = w_is_arith && (r_a[W-1] == w_b_eff_msb) && (w_acc_upd[W-1] != r_a[W-1]);
        w_flags_final = {w_acc_upd[W-1], (w_acc_upd == '0), w_overflow};
    end

    assign o_rsp_flags = r_rsp_flags;
`else
    assign o_rsp_flags = 3'b000;
`endif

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        w_state_next      = r_state;
        w_a_next          = r_a;
        w_b_next          = r_b;
        w_acc_next        = r_acc;
        w_op_next         = r_op;
        w_idx_next        = r_idx;
        w_cmd_ready_next  = r_cmd_ready;
        w_rsp_valid_next  = r_rsp_valid;
        w_rsp_result_next = r_rsp_result;
        w_rsp_carry_next  = r_rsp_carry;
        w_rsp_err_next    = r_rsp_err;
        w_alu_in1_next    = r_alu_in1;
        w_alu_in2_next    = r_alu_in2;
        w_alu_c_in_next   = r_alu_c_in;
        w_alu_op_next     = r_alu_op;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
        w_rsp_flags_next  = r_rsp_flags;
`endif
        case (r_state)
            IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_next = 1'b0;
                    if (i_cmd_op[2] && i_cmd_op[1]) begin
                        w_state_next      = RESP;
                        w_rsp_valid_next  = 1'b1;
                        w_rsp_err_next    = 1'b1;
                        w_rsp_result_next = '0;
                        w_rsp_carry_next  = 1'b0;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
                        w_rsp_flags_next  = 3'b010;
`endif
                    end else begin
                        w_state_next    = ISSUE;
                        w_a_next        = i_cmd_a;
                        w_b_next        = i_cmd_b;
                        w_op_next       = i_cmd_op;
                        w_idx_next      = 3'd0;
                        w_alu_in1_next  = w_drv_in1;
                        w_alu_in2_next  = w_drv_in2;
                        w_alu_c_in_next = w_drv_c_in;
                        w_alu_op_next   = w_drv_op;
                    end
                end
            end
            ISSUE: begin
                w_state_next = CAPT;
            end
            CAPT: begin
                w_acc_next = w_acc_upd;
                if (r_idx != LAST_IDX) begin
                    w_state_next    = ISSUE;
                    w_idx_next      = w_idx_inc;
                    w_alu_in1_next  = w_drv_in1;
                    w_alu_in2_next  = w_drv_in2;
                    w_alu_c_in_next = w_drv_c_in;
                    w_alu_op_next   = w_drv_op;
                end else begin
                    w_state_next      = RESP;
                    w_rsp_valid_next  = 1'b1;
                    w_rsp_result_next = w_acc_upd;
                    w_rsp_carry_next  = w_is_arith && i_alu_c_out;
                    w_rsp_err_next    = 1'b0;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
                    w_rsp_flags_next  = w_flags_final;
`endif
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_state_next     = IDLE;
                    w_rsp_valid_next = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    w_alu_op_next    = 25'h0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any command in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_op         <= 3'd0;
            r_idx        <= 3'd0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_alu_in1    <= 4'h0;
            r_alu_in2    <= 4'h0;
            r_alu_c_in   <= 1'b0;
            r_alu_op     <= 25'h0;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
            r_rsp_flags  <= 3'b000;
`endif
        end else begin
            r_state      <= w_state_next;
            r_a          <= w_a_next;
            r_b          <= w_b_next;
            r_acc        <= w_acc_next;
            r_op         <= w_op_next;
            r_idx        <= w_idx_next;
            r_cmd_ready  <= w_cmd_ready_next;
            r_rsp_valid  <= w_rsp_valid_next;
            r_rsp_result <= w_rsp_result_next;
            r_rsp_carry  <= w_rsp_carry_next;
            r_rsp_err    <= w_rsp_err_next;
            r_alu_in1    <= w_alu_in1_next;
            r_alu_in2    <= w_alu_in2_next;
            r_alu_c_in   <= w_alu_c_in_next;
            r_alu_op     <= w_alu_op_next;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
            r_rsp_flags  <= w_rsp_flags_next;
`endif
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_carry  = r_rsp_carry;
    assign o_rsp_err    = r_rsp_err;
    assign o_alu_in1    = r_alu_in1;
    assign o_alu_in2    = r_alu_in2;
    assign o_alu_c_in   = r_alu_c_in;
    assign o_alu_op     = r_alu_op;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: drives alu_nibble_seq against a behavioural 4-bit registered ALU.
// Expected responses are queued when commands are accepted and compared on response.
module tb_alu_nibble_seq;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
    localparam int LATENCY = 2 * NIBBLES + 1;

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         err;
        logic [2:0]   flags;
        int           latency;
    } expT;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [2:0]    cmdOp = 3'd0;
    logic [W-1:0]  cmdA = '0;
    logic [W-1:0]  cmdB = '0;
    logic          cmdCin = 1'b0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [W-1:0]  rspResult;
    logic          rspCarry;
    logic          rspErr;
    logic [2:0]    rspFlags;
    logic [3:0]    aluIn1, aluIn2;
    logic          aluCIn;
    logic [24:0]   aluOp;
    logic [3:0]    aluOut = 4'h0;
    logic          aluCOut = 1'b0;

    expT expQ[$];
    int  checkCount = 0;
    int  errorCount = 0;

    alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .i_clk        (clock),
        .i_reset      (resetN),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_op     (cmdOp),
        .i_cmd_a      (cmdA),
        .i_cmd_b      (cmdB),
        .i_cmd_cin    (cmdCin),
        .o_rsp_valid  (rspValid),
        .i_rsp_ready  (rspReady),
        .o_rsp_result (rspResult),
        .o_rsp_carry  (rspCarry),
        .o_rsp_err    (rspErr),
        .o_rsp_flags  (rspFlags),
        .o_alu_in1    (aluIn1),
        .o_alu_in2    (aluIn2),
        .o_alu_c_in   (aluCIn),
        .o_alu_op     (aluOp),
        .i_alu_out    (aluOut),
        .i_alu_c_out  (aluCOut)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Registered 4-bit ALU; logic ops leave the carry-out untouched and unknown op strings hold.
    always @(posedge clock) begin
        case (aluOp)
            25'h00002B: {aluCOut, aluOut} <= {1'b0, aluIn1} + {1'b0, aluIn2} + {4'h0, aluCIn};
            25'h000026: aluOut <= aluIn1 & aluIn2;
            25'h00007C: aluOut <= aluIn1 | aluIn2;
            25'h00005E: aluOut <= aluIn1 ^ aluIn2;
            25'h00007E: aluOut <= ~aluIn1;
            default: ;
        endcase
    end

    // Reference model of one wide command.
    function automatic expT computeExpected(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        expT e;
        logic [W:0] sum;
        logic [W-1:0] bEff;
        logic v;
        e.result = '0;
        e.carry = 1'b0;
        e.err = 1'b0;
        e.flags = 3'b000;
        e.latency = LATENCY;
        bEff = b;
        v = 1'b0;
        case (op)
            3'b000: begin
                sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                {e.carry, e.result} = sum;
            end
            3'b001: begin
                bEff = ~b;
                sum = {1'b0, a} + {1'b0, bEff} + {{W{1'b0}}, 1'b1};
                {e.carry, e.result} = sum;
            end
            3'b010: e.result = a & b;
            3'b011: e.result = a | b;
            3'b100: e.result = a ^ b;
            3'b101: e.result = ~a;
            default: begin
                e.err = 1'b1;
                e.latency = 1;
            end
        endcase
        if (op == 3'b000 || op == 3'b001) begin
            v = (a[W-1] == bEff[W-1]) && (e.result[W-1] != a[W-1]);
        end
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
        e.flags = {e.result[W-1], (e.result == '0), v};
`else
        e.flags = {2'b00, v & 1'b0};
`endif
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present a command, wait (bounded) for acceptance, and queue its expected response.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input bit expectRsp);
        int guard;
        guard = 0;
        cmdOp = op;
        cmdA = a;
        cmdB = b;
        cmdCin = cin;
        cmdValid = 1'b1;
        while (!cmdReady && guard < 40) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("acceptReady", 32'(cmdReady), 32'd1);
        @(posedge clock); #1;
        cmdValid = 1'b0;
        checkOutput("busyAfterAccept", 32'(cmdReady), 32'd0);
        if (expectRsp) expQ.push_back(computeExpected(op, a, b, cin));
    endtask

    // Wait for the response, compare it with the queue head, optionally stall, then complete the handshake.
    task automatic awaitResponse(input string tag, input int holdCycles);
        int cycles;
        expT e;
        cycles = 1;
        while (!rspValid && cycles < 40) begin
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput({tag, ".valid"}, 32'(rspValid), 32'd1);
        if (expQ.size() == 0) begin
            checkOutput({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(e.latency));
        checkOutput({tag, ".result"}, 32'(rspResult), 32'(e.result));
        checkOutput({tag, ".carry"}, 32'(rspCarry), 32'(e.carry));
        checkOutput({tag, ".err"}, 32'(rspErr), 32'(e.err));
        checkOutput({tag, ".flags"}, 32'(rspFlags), 32'(e.flags));
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clock); #1;
            checkOutput({tag, ".holdValid"}, 32'(rspValid), 32'd1);
            checkOutput({tag, ".holdResult"}, 32'(rspResult), 32'(e.result));
            checkOutput({tag, ".holdReady"}, 32'(cmdReady), 32'd0);
        end
        rspReady = 1'b1;
        @(posedge clock); #1;
        rspReady = 1'b0;
        checkOutput({tag, ".released"}, 32'(rspValid), 32'd0);
        checkOutput({tag, ".readyAgain"}, 32'(cmdReady), 32'd1);
    endtask

    // Directed cases, mid-operation reset, then a short random run.
    initial begin
        int sawRsp;
        logic [2:0] rOp;
        #12;
        checkOutput("reset.cmdReady", 32'(cmdReady), 32'd1);
        checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
        checkOutput("reset.rspResult", 32'(rspResult), 32'd0);
        checkOutput("reset.aluOp", 32'(aluOp), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock); #1;

        applyStimulus(3'b000, 16'h1234, 16'h0FFF, 1'b0, 1'b1);
        awaitResponse("add1", 0);
        applyStimulus(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        awaitResponse("addWrap", 0);
        applyStimulus(3'b000, 16'h0FFF, 16'h0000, 1'b1, 1'b1);
        awaitResponse("addCin", 0);
        applyStimulus(3'b001, 16'h1000, 16'h0001, 1'b0, 1'b1);
        awaitResponse("sub1", 0);
        applyStimulus(3'b001, 16'h0000, 16'h0001, 1'b1, 1'b1);
        awaitResponse("subBorrow", 0);
        applyStimulus(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        awaitResponse("addOvf", 0);
        applyStimulus(3'b100, 16'hA5A5, 16'hFFFF, 1'b1, 1'b1);
        awaitResponse("xorStall", 5);
        applyStimulus(3'b101, 16'h00F0, 16'h1234, 1'b0, 1'b1);
        awaitResponse("not", 0);
        applyStimulus(3'b010, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1);
        awaitResponse("and", 0);
        applyStimulus(3'b011, 16'h1200, 16'h0034, 1'b0, 1'b1);
        awaitResponse("or", 0);
        applyStimulus(3'b111, 16'h1111, 16'h2222, 1'b0, 1'b1);
        awaitResponse("illegal", 0);

        applyStimulus(3'b000, 16'h1111, 16'h2222, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("midOp.aluOp", 32'(aluOp), 32'h2B);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midReset.cmdReady", 32'(cmdReady), 32'd1);
        checkOutput("midReset.rspValid", 32'(rspValid), 32'd0);
        checkOutput("midReset.rspOut", 32'({rspResult, rspCarry, rspErr, rspFlags}), 32'd0);
        checkOutput("midReset.aluDrive", 32'({aluIn1, aluIn2, aluCIn}), 32'd0);
        checkOutput("midReset.aluOp", 32'(aluOp), 32'd0);
        @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        sawRsp = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (rspValid) sawRsp++;
        end
        checkOutput("midReset.noRsp", 32'(sawRsp), 32'd0);
        applyStimulus(3'b000, 16'h0001, 16'h0001, 1'b0, 1'b1);
        awaitResponse("afterReset", 0);

        for (int n = 0; n < 6; n++) begin
            rOp = 3'($urandom_range(5, 0));
            applyStimulus(rOp, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            awaitResponse("random", 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Command sequencer that sits directly upstream of the 4-bit ALU. It accepts one wide operation per handshake and drives the ALU operand, op-string and carry-in ports one nibble at a time, least significant first. It chains the ALU's carry-out between nibbles, then reassembles the result and returns it on a response handshake. This lets the existing 4-bit datapath execute 4·NIBBLES-bit arithmetic and logic.

## Interface
- NIBBLES, 4: operand width in nibbles; W = 4·NIBBLES; legal range 1..8.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(a); 110/111 illegal.
- cmd_a, cmd_b  in  W  operands.
- cmd_cin  in  1  carry-in for ADD; ignored otherwise.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  W  result.
- rsp_carry  out  1  final carry (ADD/SUB); 0 for logic ops.
- rsp_err  out  1  illegal cmd_op.
- rsp_flags  out  3  {N, Z, V}; see Configuration.
- alu_in1, alu_in2  out  4  ALU operands.
- alu_c_in  out  1  ALU carry-in.
- alu_op  out  25  ALU op string, 8·3+1 bits, ASCII right-aligned.
- alu_out  in  4  ALU result.
- alu_c_out  in  1  ALU carry-out.

## Operation
- Registered outputs. Reset values: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0, rsp_flags=0, alu_in1=0, alu_in2=0, alu_c_in=0, alu_op=0. An alu_op of 0 matches no ALU case, so the ALU holds.
- FSM states: IDLE, ISSUE, CAPT, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the operands, set nibble index i=0, and go to ISSUE. If the op is illegal, go straight to RESP with rsp_err=1 and rsp_result=0.
  - ISSUE: drive nibble i. Always go to CAPT.
  - CAPT: store alu_out into result[4i+3:4i] and set carry ← alu_c_out (arith ops only).
    - If i<NIBBLES-1: i++, go to ISSUE.
    - Otherwise: go to RESP.
  - RESP: rsp_valid=1, outputs stable. On rsp_ready: go to IDLE, rsp_valid=0, alu_op=0.
- Op mapping per nibble:
  - ADD: "+" with in1=a[i], in2=b[i], c_in = cmd_cin for i=0, chained carry for later nibbles.
  - SUB: "+" with in2=~b[i] and c_in = 1 for i=0, chained carry for later nibbles. This is two's-complement subtraction; rsp_carry=1 means no borrow. The ALU "-" op is never used because it ignores c_in.
  - AND/OR/XOR: "&", "|", "^".
  - NOT: "~", with in2=0.
- For logic ops, alu_c_out is ignored because the ALU does not update it; rsp_carry=0.
- cmd_ready=0 in every state except IDLE. A command presented outside IDLE is not accepted.

## Timing
- The ALU captures on the rising edge, so each nibble takes 2 cycles:
  - Operands are driven after edge k.
  - The ALU latches at edge k+1.
  - The sequencer samples at edge k+2.
- Latency from the accept edge to rsp_valid high is 2·NIBBLES+1 cycles (9 for default).
- Illegal-op latency is 1 cycle.
- Throughput: one command per 2·NIBBLES+2 cycles, provided rsp_ready is held high.
- rsp_valid is held with stable data until rsp_ready. The earliest next accept is the cycle after the response handshake.
- Reset mid-operation: all state returns to reset values immediately. The partial result is discarded and no response is issued.

## Configuration
- ALU_NIBBLE_SEQ_FLAGS_EN defined: rsp_flags is computed on entry to RESP.
  - N = rsp_result[W-1].
  - Z = (rsp_result==0).
  - V = signed overflow, from the sign bits of the effective operands and the result (ADD/SUB only; 0 for logic ops).
- Not defined: rsp_flags is tied to 3'b000 and no flag logic is synthesized.

## Test plan
- ADD a=0x1234, b=0x0FFF, cin=0 -> result 0x2233, carry 0, rsp_valid exactly 9 cycles after accept.
- ADD a=0xFFFF, b=0x0001, cin=0 -> result 0x0000, carry 1; with FLAGS_EN, flags Z=1, V=0.
- SUB a=0x1000, b=0x0001 -> result 0x0FFF, carry 1. SUB a=0x0000, b=0x0001 -> result 0xFFFF, carry 0. ADD a=0x7FFF, b=0x0001 with FLAGS_EN -> flags N=1, V=1.
- XOR a=0xA5A5, b=0xFFFF -> result 0x5A5A, carry 0. NOT a=0x00F0 -> result 0xFF0F. cmd_op=111 -> rsp_err=1, result 0, one cycle after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and result stay stable and cmd_ready stays 0. Assert rsp_ready -> next accept one cycle later.
- Assert reset during the third nibble -> all outputs return to reset values with no clock edge, and no response appears. A following ADD 0x0001+0x0001 -> result 0x0002.
